vliw_forward_unit: RTL and testbench

- Hazard-side companion to the per-lane VLIW integer datapaths.
- Tracks destination registers and write enables of every lane through the Execute, Memory and Writeback stages.
- Generates each lane's ForwardAE/ForwardBE mux selects and the 2-bit ForwardSelect_Rs1/ForwardSelect_Rs2 lane selects that those datapaths consume.
- Also raises a load-use stall request and a sticky same-bundle write-conflict error.

---
 rtl/vliw_forward_unit.sv | 162 ++++++++++++++++
 tb/tb_vliw_forward_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vliw_forward_unit.sv
// Per-lane forwarding and hazard control for the VLIW integer datapaths.
// Tracks Rd/RegWrite across E/M/W and steers each lane's operand muxes.
module vliw_forward_unit #(
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANES-1:0][4:0] Rs1D,
  input  logic [LANES-1:0][4:0] Rs2D,
  input  logic [LANES-1:0][4:0] RdD,
  input  logic [LANES-1:0]      RegWriteD,
  input  logic [LANES-1:0]      MemReadD,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  StallM,
  input  logic                  FlushM,
  input  logic                  StallW,
  input  logic                  FlushW,
  output logic [LANES-1:0][1:0] ForwardAE,
  output logic [LANES-1:0][1:0] ForwardBE,
  output logic [LANES-1:0][1:0] ForwardSelect_Rs1,
  output logic [LANES-1:0][1:0] ForwardSelect_Rs2,
  output logic                  LoadStallD,
  output logic                  WAWErr
);

  logic [LANES-1:0][4:0] rs1_e;
  logic [LANES-1:0][4:0] rs2_e;
  logic [LANES-1:0][4:0] rd_e;
  logic [LANES-1:0]      we_e;
  logic [LANES-1:0]      ld_e;
  logic [LANES-1:0][4:0] rd_m;
  logic [LANES-1:0]      we_m;
  logic [LANES-1:0][4:0] rd_w;
  logic [LANES-1:0]      we_w;
  logic                  waw_err;
  logic                  waw_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_e <= '0;
      rs2_e <= '0;
      rd_e  <= '0;
      we_e  <= '0;
      ld_e  <= '0;
    end else if (!StallE) begin
      if (FlushE) begin
        rs1_e <= '0;
        rs2_e <= '0;
        rd_e  <= '0;
        we_e  <= '0;
        ld_e  <= '0;
      end else begin
        rs1_e <= Rs1D;
        rs2_e <= Rs2D;
        rd_e  <= RdD;
        we_e  <= RegWriteD;
        ld_e  <= MemReadD;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_m <= '0;
      we_m <= '0;
    end else if (!StallM) begin
      if (FlushM) begin
        rd_m <= '0;
        we_m <= '0;
      end else begin
        rd_m <= rd_e;
        we_m <= we_e;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_w <= '0;
      we_w <= '0;
    end else if (!StallW) begin
      if (FlushW) begin
        rd_w <= '0;
        we_w <= '0;
      end else begin
        rd_w <= rd_m;
        we_w <= we_m;
      end
    end
  end

  // Scan high-to-low so the lowest matching lane is the last to win.
  function automatic logic [3:0] pick(input logic [4:0] rs);
    logic [1:0] fwd;
    logic [1:0] sel;
    logic       hit_m;
    fwd   = 2'b00;
    sel   = 2'b00;
    hit_m = 1'b0;
    if (rs != 5'd0) begin
      for (int j = LANES - 1; j >= 0; j--) begin
        if (we_m[j] && rd_m[j] == rs) begin
          hit_m = 1'b1;
          fwd   = 2'b10;
          sel   = j[1:0];
        end
      end
      if (!hit_m) begin
        for (int j = LANES - 1; j >= 0; j--) begin
          if (we_w[j] && rd_w[j] == rs) begin
            fwd = 2'b01;
            sel = j[1:0];
          end
        end
      end
    end
    return {fwd, sel};
  endfunction

  always_comb begin
    ForwardAE         = '0;
    ForwardBE         = '0;
    ForwardSelect_Rs1 = '0;
    ForwardSelect_Rs2 = '0;
    for (int i = 0; i < LANES; i++) begin
      {ForwardAE[i], ForwardSelect_Rs1[i]} = pick(rs1_e[i]);
      {ForwardBE[i], ForwardSelect_Rs2[i]} = pick(rs2_e[i]);
    end
  end

  always_comb begin
    LoadStallD = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      if (ld_e[j] && we_e[j] && rd_e[j] != 5'd0) begin
        for (int k = 0; k < LANES; k++) begin
          if (rd_e[j] == Rs1D[k] || rd_e[j] == Rs2D[k])
            LoadStallD = 1'b1;
        end
      end
    end
  end

  always_comb begin
    waw_hit = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (we_m[i] && we_m[j] &&
            rd_m[i] == rd_m[j] && rd_m[i] != 5'd0)
          waw_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        waw_err <= 1'b0;
    else if (waw_hit) waw_err <= 1'b1;
  end

  assign WAWErr = waw_err;

endmodule

// File: tb/tb_vliw_forward_unit.sv
// Scoreboard bench for vliw_forward_unit: directed hazard scenarios
// followed by randomized bundles checked against an instruction-level model.
module tb_vliw_forward_unit;

  localparam int L = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [L-1:0][4:0] rs1_d, rs2_d, rd_d;
  logic [L-1:0]      we_d, ld_d;
  logic stall_e, flush_e, stall_m, flush_m, stall_w, flush_w;
  logic [L-1:0][1:0] fa, fb, sa, sb;
  logic              ls, waw;

  vliw_forward_unit #(.LANES(L)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(rs1_d), .Rs2D(rs2_d), .RdD(rd_d),
    .RegWriteD(we_d), .MemReadD(ld_d),
    .StallE(stall_e), .FlushE(flush_e),
    .StallM(stall_m), .FlushM(flush_m),
    .StallW(stall_w), .FlushW(flush_w),
    .ForwardAE(fa), .ForwardBE(fb),
    .ForwardSelect_Rs1(sa), .ForwardSelect_Rs2(sb),
    .LoadStallD(ls), .WAWErr(waw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       we, ld;
  } slot_t;

  typedef struct {
    logic [L-1:0][1:0] fa, fb, sa, sb;
    logic              ls, waw;
  } exp_t;

  slot_t e_st[L], m_st[L], w_st[L];
  logic  sticky;
  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic void model_clear();
    for (int i = 0; i < L; i++) begin
      e_st[i] = '{default: '0};
      m_st[i] = '{default: '0};
      w_st[i] = '{default: '0};
    end
    sticky = 1'b0;
  endfunction

  // Where does operand rs come from: M beats W, lowest lane wins.
  function automatic void source(input logic [4:0] rs,
                                 output logic [1:0] f,
                                 output logic [1:0] s);
    f = 2'b00;
    s = 2'b00;
    if (rs == 5'd0) return;
    for (int j = 0; j < L; j++)
      if (m_st[j].we && m_st[j].rd == rs) begin
        f = 2'b10; s = 2'(j); return;
      end
    for (int j = 0; j < L; j++)
      if (w_st[j].we && w_st[j].rd == rs) begin
        f = 2'b01; s = 2'(j); return;
      end
  endfunction

  function automatic exp_t predict();
    exp_t x;
    x = '{default: '0};
    if (reset) return x;
    for (int i = 0; i < L; i++) begin
      source(e_st[i].rs1, x.fa[i], x.sa[i]);
      source(e_st[i].rs2, x.fb[i], x.sb[i]);
    end
    for (int j = 0; j < L; j++)
      if (e_st[j].ld && e_st[j].we && e_st[j].rd != 0)
        for (int k = 0; k < L; k++)
          if (rs1_d[k] == e_st[j].rd || rs2_d[k] == e_st[j].rd)
            x.ls = 1'b1;
    x.waw = sticky;
    return x;
  endfunction

  function automatic void model_clock();
    int cnt[32];
    for (int r = 0; r < 32; r++) cnt[r] = 0;
    for (int j = 0; j < L; j++)
      if (m_st[j].we && m_st[j].rd != 0) cnt[m_st[j].rd]++;
    for (int r = 1; r < 32; r++) if (cnt[r] > 1) sticky = 1'b1;
    if (!stall_w)
      for (int j = 0; j < L; j++)
        w_st[j] = flush_w ? '{default: '0} : m_st[j];
    if (!stall_m)
      for (int j = 0; j < L; j++)
        m_st[j] = flush_m ? '{default: '0} : e_st[j];
    if (!stall_e)
      for (int j = 0; j < L; j++)
        e_st[j] = flush_e ? '{default: '0} :
          '{rs1: rs1_d[j], rs2: rs2_d[j], rd: rd_d[j],
            we: we_d[j], ld: ld_d[j]};
  endfunction

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ForwardAE", 8'(fa), 8'(e.fa));
      check("ForwardBE", 8'(fb), 8'(e.fb));
      check("SelRs1", 8'(sa), 8'(e.sa));
      check("SelRs2", 8'(sb), 8'(e.sb));
      check("LoadStallD", 8'(ls), 8'(e.ls));
      check("WAWErr", 8'(waw), 8'(e.waw));
    end
  end

  // Called at a negedge with this cycle's inputs already applied.
  task automatic cycle();
    if (reset) model_clear();
    exp_q.push_back(predict());
    @(posedge clk);
    if (!reset) model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    rs1_d = '0; rs2_d = '0; rd_d = '0; we_d = '0; ld_d = '0;
    stall_e = 0; flush_e = 0; stall_m = 0;
    flush_m = 0; stall_w = 0; flush_w = 0;
  endtask

  task automatic rand_d(input int regs);
    for (int i = 0; i < L; i++) begin
      rs1_d[i] = 5'($urandom_range(regs));
      rs2_d[i] = 5'($urandom_range(regs));
      rd_d[i]  = 5'($urandom_range(regs));
      we_d[i]  = 1'($urandom);
      ld_d[i]  = ($urandom_range(3) == 0);
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      rand_d(31);
      cycle();
    end
    reset = 1'b0;
    idle();
    repeat (3) cycle();

    // Lane 2 produces x5; lane 0 consumes it one bundle later.
    rd_d[2] = 5; we_d[2] = 1; cycle();
    idle(); rs1_d[0] = 5; cycle();
    idle(); repeat (3) cycle();

    // x7 written by lane 3 (ends in W) and lane 1 (ends in M).
    rd_d[3] = 7; we_d[3] = 1; cycle();
    idle(); rd_d[1] = 7; we_d[1] = 1; cycle();
    idle(); rs2_d[0] = 7; cycle();
    idle(); repeat (3) cycle();

    // Writes to x0 never forward.
    rd_d[0] = 0; we_d[0] = 1; cycle();
    idle(); rs1_d[0] = 0; rs2_d[1] = 0; cycle();
    idle(); repeat (3) cycle();

    // Load-use on x9, resolved by flushing E while D holds.
    rd_d[3] = 9; we_d[3] = 1; ld_d[3] = 1; cycle();
    idle(); rs2_d[1] = 9; flush_e = 1; cycle();
    flush_e = 0; cycle();
    idle(); repeat (3) cycle();

    // Same-bundle WAW on x4, then a held M, then reset mid-stream.
    rd_d[0] = 4; we_d[0] = 1; rd_d[2] = 4; we_d[2] = 1; cycle();
    idle(); repeat (12) cycle();
    stall_m = 1; flush_m = 1; rd_d[1] = 3; we_d[1] = 1;
    repeat (2) cycle();
    idle(); rs1_d[2] = 3; repeat (2) cycle();
    reset = 1'b1; rand_d(7); cycle();
    reset = 1'b0; idle(); repeat (2) cycle();

    for (int c = 0; c < 3000; c++) begin
      rand_d(7);
      stall_e = ($urandom_range(7) == 0);
      flush_e = ($urandom_range(7) == 0);
      stall_m = ($urandom_range(7) == 0);
      flush_m = ($urandom_range(9) == 0);
      stall_w = ($urandom_range(7) == 0);
      flush_w = ($urandom_range(9) == 0);
      reset   = ($urandom_range(499) == 0);
      cycle();
    end
    reset = 1'b0;
    idle();
    repeat (3) cycle();
    repeat (3) @(negedge clk);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
